// File: rtl/matrix_transpose_if.sv
// Start handshake plus the source-read and destination-write SRAM ports of matrix_transpose.
// The engine side (master) drives the SRAM addresses and start_ready.
interface matrix_transpose_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
);
   logic              start_valid;
   logic              start_ready;
   logic [ADDR_W-1:0] src_base;
   logic [ADDR_W-1:0] dst_base;
   logic [ADDR_W-1:0] src_rd_addr;
   logic [DATA_W-1:0] src_rd_data;
   logic              dst_wr_en;
   logic [ADDR_W-1:0] dst_wr_addr;
   logic [DATA_W-1:0] dst_wr_data;

   modport master (
      input  start_valid, src_base, dst_base, src_rd_data,
      output start_ready, src_rd_addr, dst_wr_en, dst_wr_addr, dst_wr_data
   );

   modport slave (
      output start_valid, src_base, dst_base, src_rd_data,
      input  start_ready, src_rd_addr, dst_wr_en, dst_wr_addr, dst_wr_data
   );
endinterface

// File: rtl/matrix_transpose.sv
// Copies a row-major {rows, cols}-headed matrix from the result SRAM into a destination
// SRAM in transposed order, rewriting the header as {cols, rows}.
module matrix_transpose #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
) (
   input  logic               clk,
   input  logic               reset,
   matrix_transpose_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_HDR_RD, S_HDR_CAP, S_XFER, S_DRAIN, S_DONE
   } state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic              w_accept;
   logic              w_last;
   logic              w_empty;
   logic [15:0]       w_hdr_rows;
   logic [15:0]       w_hdr_cols;

   logic              r_ready;
   logic [ADDR_W-1:0] r_rd_addr;
   logic [ADDR_W-1:0] r_col_ptr;
   logic [ADDR_W-1:0] r_dst_base;
   logic              r_wr_en;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [DATA_W-1:0] r_hdr_word;
   logic              r_fwd;
   logic [15:0]       r_rows;
   logic [15:0]       r_cols;
   logic [15:0]       r_row_idx;
   logic [15:0]       r_col_idx;

   assign w_hdr_rows = bus.src_rd_data[31:16];
   assign w_hdr_cols = bus.src_rd_data[15:0];
   assign w_empty    = (w_hdr_rows == 16'd0) || (w_hdr_cols == 16'd0);
   assign w_last     = (r_row_idx == r_rows - 16'd1) && (r_col_idx == r_cols - 16'd1);

   // NOTE: sequential state uses nonblocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      unique case (r_state)
         // DONE is the first ready cycle and accepts exactly like IDLE.
         S_IDLE, S_DONE: begin
            if (r_ready && bus.start_valid) begin
               w_accept     = 1'b1;
               w_next_state = S_HDR_RD;
            end else begin
               w_next_state = S_IDLE;
            end
         end
         S_HDR_RD:  w_next_state = S_HDR_CAP;
         S_HDR_CAP: w_next_state = w_empty ? S_DRAIN : S_XFER;
         S_XFER:    w_next_state = w_last ? S_DRAIN : S_XFER;
         S_DRAIN:   w_next_state = S_DONE;
         default:   w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ready    <= 1'b0;
         r_rd_addr  <= '0;
         r_col_ptr  <= '0;
         r_dst_base <= '0;
         r_wr_en    <= 1'b0;
         r_wr_addr  <= '0;
         r_hdr_word <= '0;
         r_fwd      <= 1'b0;
         r_rows     <= '0;
         r_cols     <= '0;
         r_row_idx  <= '0;
         r_col_idx  <= '0;
      end else begin
         r_ready <= (w_next_state == S_IDLE) || (w_next_state == S_DONE);
         r_wr_en <= 1'b0;
         r_fwd   <= 1'b0;
         unique case (r_state)
            S_IDLE, S_DONE: begin
               if (w_accept) begin
                  r_rd_addr  <= bus.src_base;
                  r_col_ptr  <= bus.src_base + ADDR_W'(1);
                  r_dst_base <= bus.dst_base;
               end
            end
            S_HDR_CAP: begin
               r_rows     <= w_hdr_rows;
               r_cols     <= w_hdr_cols;
               r_row_idx  <= '0;
               r_col_idx  <= '0;
               r_wr_en    <= 1'b1;
               r_wr_addr  <= r_dst_base;
               r_hdr_word <= DATA_W'({w_hdr_cols, w_hdr_rows});
               if (!w_empty) r_rd_addr <= r_col_ptr;
            end
            S_XFER: begin
               // Strobe for the element whose read is presented now; its word arrives next cycle.
               r_wr_en   <= 1'b1;
               r_fwd     <= 1'b1;
               r_wr_addr <= r_wr_addr + ADDR_W'(1);
               if (r_row_idx == r_rows - 16'd1) begin
                  r_row_idx <= '0;
                  r_col_idx <= r_col_idx + 16'd1;
                  r_col_ptr <= r_col_ptr + ADDR_W'(1);
                  r_rd_addr <= r_col_ptr + ADDR_W'(1);
               end else begin
                  r_row_idx <= r_row_idx + 16'd1;
                  r_rd_addr <= r_rd_addr + ADDR_W'(r_cols);
               end
            end
            default: ;
         endcase
      end
   end

   // Element words go straight from the SRAM read port under the registered strobe/address,
   // so each write lands one cycle after its read; the header comes from r_hdr_word.
   assign bus.start_ready = r_ready;
   assign bus.src_rd_addr = r_rd_addr;
   assign bus.dst_wr_en   = r_wr_en;
   assign bus.dst_wr_addr = r_wr_addr;
   assign bus.dst_wr_data = r_fwd ? bus.src_rd_data : r_hdr_word;

endmodule
